// File: rtl/gold_ring_pkg.sv
// gold_ring_pkg
//   Shared constants for the gold ring router: flit field positions and the
//   port indices used to address the three router ports (PE, CW, CCW).
//   Also provides small helpers to read and replace the hop field of a flit.
package gold_ring_pkg;

  localparam int DATA_W  = 64;
  localparam int VC_BIT  = 63;
  localparam int DIR_BIT = 62;
  localparam int HOP_LSB = 48;
  localparam int HOP_W   = 8;

  // Port indices; every per-port array in the router is indexed by these.
  localparam int PE  = 0;
  localparam int CW  = 1;
  localparam int CCW = 2;

  // Extract the hop count from a flit.
  function automatic logic [HOP_W-1:0] get_hop(input logic [DATA_W-1:0] flit);
    return flit[HOP_LSB +: HOP_W];
  endfunction

  // Return a copy of the flit with only the hop field replaced.
  function automatic logic [DATA_W-1:0] set_hop(input logic [DATA_W-1:0] flit,
                                                input logic [HOP_W-1:0]  hop);
    logic [DATA_W-1:0] res;
    res = flit;
    res[HOP_LSB +: HOP_W] = hop;
    return res;
  endfunction

endpackage

// File: rtl/gold_ring_router_if.sv
// gold_ring_router_if
//   One unidirectional flit link: send/ready handshake plus 64-bit data.
//   A transfer happens on a clock edge where send and ready are both high.
//   Ports (signals):
//     send  - sender has a flit on data
//     ready - receiver can accept this cycle
//     data  - flit
//   Modports: master = sending side, slave = receiving side.
interface gold_ring_router_if;
  import gold_ring_pkg::*;

  logic              send;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output send, output data, input ready);
  modport slave  (input send, input data, output ready);

endinterface

// File: rtl/gold_vc_buf.sv
// gold_vc_buf
//   Two-entry flit holder, one entry per virtual channel. Each entry has a
//   full flag. A write and a clear may happen in the same cycle as long as
//   they address different VCs (the router guarantees this).
//   Ports:
//     clk, reset        - clock, asynchronous active-high reset
//     wr_en/wr_vc/wr_data - load wr_data into entry wr_vc and mark it full
//     clr_en/clr_vc     - mark entry clr_vc empty
//     rd_vc/rd_data     - read mux of the entry data
//     full              - per-VC full flags
module gold_vc_buf
  import gold_ring_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              wr_vc,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_en,
  input  logic              clr_vc,
  input  logic              rd_vc,
  output logic [1:0]        full,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2];

  // Entry storage and full flags; write wins over clear for the same VC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full   <= 2'b00;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      for (int v = 0; v < 2; v++) begin
        if (wr_en && (wr_vc == v[0])) begin
          full[v] <= 1'b1;
          mem[v]  <= wr_data;
        end else if (clr_en && (clr_vc == v[0])) begin
          full[v] <= 1'b0;
        end else begin
          full[v] <= full[v];
        end
      end
    end
  end

  assign rd_data = mem[rd_vc];

endmodule

// File: rtl/gold_ring_router.sv
// gold_ring_router
//   One node of a 4-node bidirectional ring. Two virtual channels; a global
//   polarity bit p alternates every cycle. VC p talks to the external links
//   (send from output buffers, accept into input buffers) while VC ~p moves
//   flits from input buffers to output buffers with routing/arbitration.
//   Ports:
//     clk, reset        - clock, asynchronous active-high reset
//     cw_in / ccw_in    - ring input links (slave)
//     cw_out / ccw_out  - ring output links (master)
//     pe_in / pe_out    - NIC injection / ejection links
//     polarity          - current polarity
module gold_ring_router
  import gold_ring_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  gold_ring_router_if.slave         cw_in,
  gold_ring_router_if.master        cw_out,
  gold_ring_router_if.slave         ccw_in,
  gold_ring_router_if.master        ccw_out,
  gold_ring_router_if.slave         pe_in,
  gold_ring_router_if.master        pe_out,
  output logic                      polarity
);

  logic              q;
  logic              in_send  [3];
  logic [DATA_W-1:0] in_data  [3];
  logic              in_rdy   [3];
  logic              in_wr    [3];
  logic              in_clr   [3];
  logic [1:0]        in_full  [3];
  logic [DATA_W-1:0] in_qdata [3];
  logic              out_rdy  [3];
  logic              out_send [3];
  logic [DATA_W-1:0] out_dout [3];
  logic              out_wr   [3];
  logic              out_clr  [3];
  logic [DATA_W-1:0] out_wdata[3];
  logic [1:0]        out_full [3];
  logic [DATA_W-1:0] out_pdata[3];

  // Round-robin pointers, one bit per VC, for each contended output.
  logic [1:0] rr_pe, rr_cw, rr_ccw;
  logic [1:0] rr_pe_nxt, rr_cw_nxt, rr_ccw_nxt;

  assign q = ~polarity;

  assign in_send[PE]  = pe_in.send;
  assign in_send[CW]  = cw_in.send;
  assign in_send[CCW] = ccw_in.send;
  assign in_data[PE]  = pe_in.data;
  assign in_data[CW]  = cw_in.data;
  assign in_data[CCW] = ccw_in.data;
  assign pe_in.ready  = in_rdy[PE];
  assign cw_in.ready  = in_rdy[CW];
  assign ccw_in.ready = in_rdy[CCW];

  assign out_rdy[PE]  = pe_out.ready;
  assign out_rdy[CW]  = cw_out.ready;
  assign out_rdy[CCW] = ccw_out.ready;
  assign pe_out.send  = out_send[PE];
  assign cw_out.send  = out_send[CW];
  assign ccw_out.send = out_send[CCW];
  assign pe_out.data  = out_dout[PE];
  assign cw_out.data  = out_dout[CW];
  assign ccw_out.data = out_dout[CCW];

  // Input buffers are written on VC p and drained on VC q; output buffers the reverse.
  for (genvar i = 0; i < 3; i++) begin : g_buf
    gold_vc_buf u_in (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (in_wr[i]),
      .wr_vc   (polarity),
      .wr_data (in_data[i]),
      .clr_en  (in_clr[i]),
      .clr_vc  (q),
      .rd_vc   (q),
      .full    (in_full[i]),
      .rd_data (in_qdata[i])
    );
    gold_vc_buf u_out (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (out_wr[i]),
      .wr_vc   (q),
      .wr_data (out_wdata[i]),
      .clr_en  (out_clr[i]),
      .clr_vc  (polarity),
      .rd_vc   (polarity),
      .full    (out_full[i]),
      .rd_data (out_pdata[i])
    );
  end

  // Polarity flips every cycle out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      polarity <= 1'b0;
    end else begin
      polarity <= ~polarity;
    end
  end

  // Arbitration pointer state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_pe  <= 2'b00;
      rr_cw  <= 2'b00;
      rr_ccw <= 2'b00;
    end else begin
      rr_pe  <= rr_pe_nxt;
      rr_cw  <= rr_cw_nxt;
      rr_ccw <= rr_ccw_nxt;
    end
  end

  // External phase on VC p: link handshakes, output send/clear, input capture.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      in_rdy[i]   = ~in_full[i][polarity];
      in_wr[i]    = in_send[i] & in_rdy[i];
      out_send[i] = out_full[i][polarity] & out_rdy[i];
      out_clr[i]  = out_send[i];
      out_dout[i] = out_send[i] ? out_pdata[i] : {DATA_W{1'b0}};
    end
  end

  // Routing requests for the flits sitting in the VC q input entries.
  logic              v_pe, v_cw, v_ccw;
  logic              cw_eject, ccw_eject, pe_loop, pe_dir;
  logic [DATA_W-1:0] cw_fwd, ccw_fwd;
  logic              r_pe_cw, r_pe_ccw, r_pe_pe;
  logic              r_cw_cw, r_cw_pe, r_ccw_ccw, r_ccw_pe;

  assign v_pe      = in_full[PE][q];
  assign v_cw      = in_full[CW][q];
  assign v_ccw     = in_full[CCW][q];
  assign cw_eject  = (get_hop(in_qdata[CW])  == 8'd1);
  assign ccw_eject = (get_hop(in_qdata[CCW]) == 8'd1);
  assign pe_loop   = (get_hop(in_qdata[PE])  == 8'd0);
  assign pe_dir    = in_qdata[PE][DIR_BIT];
  // Ring flits always lose one hop; hop 1 becomes 0 on ejection, hop 0 wraps to 255.
  assign cw_fwd    = set_hop(in_qdata[CW],  get_hop(in_qdata[CW])  - 8'd1);
  assign ccw_fwd   = set_hop(in_qdata[CCW], get_hop(in_qdata[CCW]) - 8'd1);

  assign r_pe_cw   = v_cw  &  cw_eject;
  assign r_pe_ccw  = v_ccw &  ccw_eject;
  assign r_pe_pe   = v_pe  &  pe_loop;
  assign r_cw_cw   = v_cw  & ~cw_eject;
  assign r_cw_pe   = v_pe  & ~pe_loop & ~pe_dir;
  assign r_ccw_ccw = v_ccw & ~ccw_eject;
  assign r_ccw_pe  = v_pe  & ~pe_loop &  pe_dir;

  logic g_pe_cw, g_pe_ccw, g_pe_pe, g_cw_cw, g_cw_pe, g_ccw_ccw, g_ccw_pe;

  // Internal phase on VC q: per-output arbitration and input-to-output moves.
  always_comb begin
    g_pe_cw    = 1'b0;
    g_pe_ccw   = 1'b0;
    g_pe_pe    = 1'b0;
    g_cw_cw    = 1'b0;
    g_cw_pe    = 1'b0;
    g_ccw_ccw  = 1'b0;
    g_ccw_pe   = 1'b0;
    rr_pe_nxt  = rr_pe;
    rr_cw_nxt  = rr_cw;
    rr_ccw_nxt = rr_ccw;

    // PE output: CW vs CCW round robin; loopback only when no ring flit wants it.
    if (~out_full[PE][q]) begin
      if (r_pe_cw && r_pe_ccw) begin
        g_pe_cw       = ~rr_pe[q];
        g_pe_ccw      =  rr_pe[q];
        rr_pe_nxt[q]  = ~rr_pe[q];
      end else begin
        g_pe_cw  = r_pe_cw;
        g_pe_ccw = r_pe_ccw;
        g_pe_pe  = ~r_pe_cw & ~r_pe_ccw & r_pe_pe;
      end
    end else begin
      g_pe_cw = 1'b0;
    end

    // CW output: pointer 0 favours the ring input.
    if (~out_full[CW][q]) begin
      if (r_cw_cw && r_cw_pe) begin
        g_cw_cw      = ~rr_cw[q];
        g_cw_pe      =  rr_cw[q];
        rr_cw_nxt[q] = ~rr_cw[q];
      end else begin
        g_cw_cw = r_cw_cw;
        g_cw_pe = r_cw_pe;
      end
    end else begin
      g_cw_cw = 1'b0;
    end

    // CCW output: mirror of the CW output.
    if (~out_full[CCW][q]) begin
      if (r_ccw_ccw && r_ccw_pe) begin
        g_ccw_ccw     = ~rr_ccw[q];
        g_ccw_pe      =  rr_ccw[q];
        rr_ccw_nxt[q] = ~rr_ccw[q];
      end else begin
        g_ccw_ccw = r_ccw_ccw;
        g_ccw_pe  = r_ccw_pe;
      end
    end else begin
      g_ccw_ccw = 1'b0;
    end

    out_wr[PE]     = g_pe_cw | g_pe_ccw | g_pe_pe;
    out_wdata[PE]  = g_pe_cw ? cw_fwd : (g_pe_ccw ? ccw_fwd : in_qdata[PE]);
    out_wr[CW]     = g_cw_cw | g_cw_pe;
    out_wdata[CW]  = g_cw_cw ? cw_fwd : in_qdata[PE];
    out_wr[CCW]    = g_ccw_ccw | g_ccw_pe;
    out_wdata[CCW] = g_ccw_ccw ? ccw_fwd : in_qdata[PE];

    in_clr[PE]     = g_pe_pe | g_cw_pe | g_ccw_pe;
    in_clr[CW]     = g_pe_cw | g_cw_cw;
    in_clr[CCW]    = g_pe_ccw | g_ccw_ccw;
  end

endmodule

// File: tb/tb_gold_ring_router.sv
// tb_gold_ring_router
//   Directed scenarios for reset, injection, ejection, forwarding,
//   backpressure and arbitration, followed by randomized traffic checked
//   against a delivery scoreboard (each accepted flit must appear exactly
//   once at the output chosen by the hop/dir rules, transformed as expected).
module tb_gold_ring_router;
  import gold_ring_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic polarity;
  always #5 clk = ~clk;

  gold_ring_router_if cw_in_if ();
  gold_ring_router_if cw_out_if ();
  gold_ring_router_if ccw_in_if ();
  gold_ring_router_if ccw_out_if ();
  gold_ring_router_if pe_in_if ();
  gold_ring_router_if pe_out_if ();

  gold_ring_router dut (
    .clk      (clk),
    .reset    (reset),
    .cw_in    (cw_in_if.slave),
    .cw_out   (cw_out_if.master),
    .ccw_in   (ccw_in_if.slave),
    .ccw_out  (ccw_out_if.master),
    .pe_in    (pe_in_if.slave),
    .pe_out   (pe_out_if.master),
    .polarity (polarity)
  );

  int total = 0;
  int bad   = 0;
  logic [15:0] tag_ctr = 16'd0;
  logic [63:0] got_q[$];

  typedef struct {
    int          dst;
    logic [63:0] d;
  } exp_t;
  exp_t sb[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int i, input logic s, input logic [63:0] d);
    case (i)
      PE:      begin pe_in_if.send  = s; pe_in_if.data  = d; end
      CW:      begin cw_in_if.send  = s; cw_in_if.data  = d; end
      default: begin ccw_in_if.send = s; ccw_in_if.data = d; end
    endcase
  endtask

  task automatic set_ro(input int o, input logic r);
    case (o)
      PE:      pe_out_if.ready  = r;
      CW:      cw_out_if.ready  = r;
      default: ccw_out_if.ready = r;
    endcase
  endtask

  function automatic logic get_ri(input int i);
    case (i)
      PE:      return pe_in_if.ready;
      CW:      return cw_in_if.ready;
      default: return ccw_in_if.ready;
    endcase
  endfunction

  function automatic logic get_so(input int o);
    case (o)
      PE:      return pe_out_if.send;
      CW:      return cw_out_if.send;
      default: return ccw_out_if.send;
    endcase
  endfunction

  function automatic logic [63:0] get_do(input int o);
    case (o)
      PE:      return pe_out_if.data;
      CW:      return cw_out_if.data;
      default: return ccw_out_if.data;
    endcase
  endfunction

  function automatic logic [63:0] mk(input logic dir, input logic [7:0] hop,
                                     input logic [15:0] src, input logic [31:0] pay);
    return {1'b0, dir, 6'b000000, hop, src, pay};
  endfunction

  // Reference routing: destination port and the flit as it should leave.
  function automatic void route(input int src, input logic [63:0] f,
                                output int dst, output logic [63:0] e);
    logic [7:0] h;
    h = f[HOP_LSB +: HOP_W];
    e = f;
    if (src == PE) begin
      if (h == 8'd0) dst = PE;
      else if (f[DIR_BIT]) dst = CCW;
      else dst = CW;
    end else if (h == 8'd1) begin
      dst = PE;
      e[HOP_LSB +: HOP_W] = 8'd0;
    end else begin
      dst = src;
      e[HOP_LSB +: HOP_W] = (h == 8'd0) ? 8'd255 : (h - 8'd1);
    end
  endfunction

  task automatic idle();
    for (int i = 0; i < 3; i++) begin
      set_in(i, 1'b0, 64'd0);
      set_ro(i, 1'b1);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Record flits leaving output o over n cycles.
  task automatic collect(input int o, input int n);
    got_q.delete();
    for (int k = 0; k < n; k++) begin
      if (get_so(o) === 1'b1) got_q.push_back(get_do(o));
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    #1;
    total++;
    if (polarity !== 1'b0) begin bad++; $display("FAIL reset_pol got=%b want=0", polarity); end
    for (int i = 0; i < 3; i++) begin
      total += 3;
      if (get_so(i) !== 1'b0) begin bad++; $display("FAIL reset_so[%0d] got=%b want=0", i, get_so(i)); end
      if (get_do(i) !== 64'd0) begin bad++; $display("FAIL reset_do[%0d] got=%h want=0", i, get_do(i)); end
      if (get_ri(i) !== 1'b1) begin bad++; $display("FAIL reset_ri[%0d] got=%b want=1", i, get_ri(i)); end
    end
    tick();
    reset = 1'b0;
    // Capture a flit, then reset before it can leave.
    set_in(PE, 1'b1, mk(1'b0, 8'd1, 16'hDEAD, 32'h1234_5678));
    tick();
    set_in(PE, 1'b0, 64'd0);
    reset = 1'b1;
    #1;
    total++;
    if (polarity !== 1'b0) begin bad++; $display("FAIL midreset_pol got=%b want=0", polarity); end
    tick();
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      total++;
      if (cw_out_if.send !== 1'b0 || cw_out_if.data !== 64'd0) begin
        bad++;
        $display("FAIL midreset_flush cyc=%0d got so=%b do=%h want so=0 do=0", k, cw_out_if.send, cw_out_if.data);
      end
      tick();
    end
  endtask

  task automatic test_pe_inject();
    logic [63:0] f;
    f = 64'h0001_0100_0005_ABCD;
    apply_reset();
    set_in(PE, 1'b1, f);
    #1;
    total++;
    if (pe_in_if.ready !== 1'b1) begin bad++; $display("FAIL inj_ready got=%b want=1", pe_in_if.ready); end
    tick();
    set_in(PE, 1'b0, 64'd0);
    total++;
    if (cw_out_if.send !== 1'b0) begin bad++; $display("FAIL inj_early got=%b want=0", cw_out_if.send); end
    tick();
    total += 4;
    if (polarity !== 1'b0) begin bad++; $display("FAIL inj_pol got=%b want=0", polarity); end
    if (cw_out_if.send !== 1'b1) begin bad++; $display("FAIL inj_so got=%b want=1", cw_out_if.send); end
    if (cw_out_if.data !== f) begin bad++; $display("FAIL inj_do got=%h want=%h", cw_out_if.data, f); end
    if (ccw_out_if.send !== 1'b0 || pe_out_if.send !== 1'b0) begin
      bad++; $display("FAIL inj_other got ccw=%b pe=%b want 0 0", ccw_out_if.send, pe_out_if.send);
    end
    tick();
    total++;
    if (cw_out_if.send !== 1'b0) begin bad++; $display("FAIL inj_clear got=%b want=0", cw_out_if.send); end
  endtask

  task automatic test_eject();
    apply_reset();
    tick();
    set_in(CW, 1'b1, mk(1'b0, 8'd1, 16'h0042, 32'hCAFE_F00D));
    tick();
    set_in(CW, 1'b0, 64'd0);
    tick();
    total += 2;
    if (pe_out_if.send !== 1'b1) begin bad++; $display("FAIL eject_so got=%b want=1", pe_out_if.send); end
    if (pe_out_if.data !== 64'h0000_0042_CAFE_F00D) begin
      bad++; $display("FAIL eject_do got=%h want=%h", pe_out_if.data, 64'h0000_0042_CAFE_F00D);
    end
  endtask

  task automatic test_forward();
    apply_reset();
    set_in(CCW, 1'b1, mk(1'b1, 8'd3, 16'h0777, 32'h0BAD_BEEF));
    tick();
    set_in(CCW, 1'b0, 64'd0);
    total++;
    if (ccw_out_if.send !== 1'b0) begin bad++; $display("FAIL fwd_early got=%b want=0", ccw_out_if.send); end
    tick();
    total += 3;
    if (ccw_out_if.send !== 1'b1) begin bad++; $display("FAIL fwd_so got=%b want=1", ccw_out_if.send); end
    if (ccw_out_if.data !== 64'h4002_0777_0BAD_BEEF) begin
      bad++; $display("FAIL fwd_do got=%h want=%h", ccw_out_if.data, 64'h4002_0777_0BAD_BEEF);
    end
    if (cw_out_if.send !== 1'b0 || pe_out_if.send !== 1'b0) begin
      bad++; $display("FAIL fwd_other got cw=%b pe=%b want 0 0", cw_out_if.send, pe_out_if.send);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] fa, fb, fc, ea, eb, ec;
    int dst;
    fa = mk(1'b0, 8'd5, 16'h00A0, 32'hAAAA_0001);
    fb = mk(1'b0, 8'd6, 16'h00B0, 32'hBBBB_0002);
    fc = mk(1'b0, 8'd7, 16'h00C0, 32'hCCCC_0003);
    route(CW, fa, dst, ea);
    route(CW, fb, dst, eb);
    route(CW, fc, dst, ec);
    apply_reset();
    set_ro(CW, 1'b0);
    set_in(CW, 1'b1, fa);
    tick();
    set_in(CW, 1'b0, 64'd0);
    tick();
    for (int k = 0; k < 6; k++) begin
      if (k == 0) set_in(CW, 1'b1, fb);
      #1;
      total++;
      if (cw_out_if.send !== 1'b0) begin bad++; $display("FAIL bp_hold cyc=%0d got=%b want=0", k, cw_out_if.send); end
      tick();
      set_in(CW, 1'b0, 64'd0);
    end
    set_in(CW, 1'b1, fc);
    #1;
    total++;
    if (cw_in_if.ready !== 1'b0) begin bad++; $display("FAIL bp_ri got=%b want=0", cw_in_if.ready); end
    set_ro(CW, 1'b1);
    got_q.delete();
    for (int k = 0; k < 16; k++) begin
      logic acc;
      #1;
      acc = cw_in_if.send & cw_in_if.ready;
      if (cw_out_if.send === 1'b1) got_q.push_back(cw_out_if.data);
      tick();
      if (acc) set_in(CW, 1'b0, 64'd0);
    end
    total++;
    if (got_q.size() != 3) begin
      bad++; $display("FAIL bp_count got=%0d want=3", got_q.size());
    end else begin
      total += 3;
      if (got_q[0] !== ea) begin bad++; $display("FAIL bp_order0 got=%h want=%h", got_q[0], ea); end
      if (got_q[1] !== eb) begin bad++; $display("FAIL bp_order1 got=%h want=%h", got_q[1], eb); end
      if (got_q[2] !== ec) begin bad++; $display("FAIL bp_order2 got=%h want=%h", got_q[2], ec); end
    end
  endtask

  task automatic test_arbitration();
    logic [15:0] want0, want1;
    apply_reset();
    // Ring vs ring for the PE output.
    for (int r = 0; r < 4; r++) begin
      while (polarity !== 1'b0) tick();
      set_in(CW,  1'b1, mk(1'b0, 8'd1, 16'h1000 + 16'(r), 32'h0));
      set_in(CCW, 1'b1, mk(1'b1, 8'd1, 16'h2000 + 16'(r), 32'h0));
      tick();
      set_in(CW,  1'b0, 64'd0);
      set_in(CCW, 1'b0, 64'd0);
      collect(PE, 8);
      want0 = (r % 2 == 0) ? 16'h1000 + 16'(r) : 16'h2000 + 16'(r);
      want1 = (r % 2 == 0) ? 16'h2000 + 16'(r) : 16'h1000 + 16'(r);
      total++;
      if (got_q.size() != 2 || got_q[0][47:32] !== want0 || got_q[1][47:32] !== want1) begin
        bad++;
        $display("FAIL arb_pe round=%0d got n=%0d first=%h want first=%h second=%h",
                 r, got_q.size(), (got_q.size() > 0) ? got_q[0][47:32] : 16'hxxxx, want0, want1);
      end
    end
    // PE injection vs CW ring traffic for the CW output.
    for (int r = 0; r < 4; r++) begin
      while (polarity !== 1'b0) tick();
      set_in(CW, 1'b1, mk(1'b0, 8'd3, 16'h3000 + 16'(r), 32'h0));
      set_in(PE, 1'b1, mk(1'b0, 8'd2, 16'h4000 + 16'(r), 32'h0));
      tick();
      set_in(CW, 1'b0, 64'd0);
      set_in(PE, 1'b0, 64'd0);
      collect(CW, 8);
      want0 = (r % 2 == 0) ? 16'h3000 + 16'(r) : 16'h4000 + 16'(r);
      want1 = (r % 2 == 0) ? 16'h4000 + 16'(r) : 16'h3000 + 16'(r);
      total++;
      if (got_q.size() != 2 || got_q[0][47:32] !== want0 || got_q[1][47:32] !== want1) begin
        bad++;
        $display("FAIL arb_cw round=%0d got n=%0d first=%h want first=%h second=%h",
                 r, got_q.size(), (got_q.size() > 0) ? got_q[0][47:32] : 16'hxxxx, want0, want1);
      end
      total++;
      if (got_q.size() == 2 && got_q[0][HOP_LSB +: HOP_W] !== 8'd2) begin
        bad++; $display("FAIL arb_cw_hop round=%0d got=%0d want=2", r, got_q[0][HOP_LSB +: HOP_W]);
      end
    end
  endtask

  // Check every sending output against the scoreboard; remove matches.
  task automatic check_outputs();
    for (int o = 0; o < 3; o++) begin
      if (get_so(o) === 1'b1) begin
        int hit;
        hit = -1;
        for (int j = 0; j < sb.size(); j++) begin
          if (hit < 0 && sb[j].dst == o && sb[j].d === get_do(o)) hit = j;
        end
        total++;
        if (hit < 0) begin
          bad++; $display("FAIL rand_unexpected port=%0d got=%h want=a scoreboard flit", o, get_do(o));
        end else begin
          sb.delete(hit);
        end
      end
    end
  endtask

  task automatic test_random();
    logic        pend [3];
    logic [63:0] cur  [3];
    apply_reset();
    sb.delete();
    for (int i = 0; i < 3; i++) begin pend[i] = 1'b0; cur[i] = 64'd0; end
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] && c < 600 && $urandom_range(0, 2) == 0) begin
          tag_ctr = tag_ctr + 16'd1;
          cur[i]  = {$urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                     6'($urandom), 8'($urandom_range(0, 3)), tag_ctr, 32'($urandom)};
          pend[i] = 1'b1;
        end
        set_in(i, pend[i], pend[i] ? cur[i] : 64'd0);
        set_ro(i, (c >= 600) || ($urandom_range(0, 3) != 0));
      end
      #1;
      check_outputs();
      for (int i = 0; i < 3; i++) begin
        if (pend[i] && get_ri(i) === 1'b1) begin
          exp_t e;
          route(i, cur[i], e.dst, e.d);
          sb.push_back(e);
          pend[i] = 1'b0;
        end
      end
      tick();
    end
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL rand_undelivered got=%0d want=0", sb.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_pe_inject();
    test_eject();
    test_forward();
    test_backpressure();
    test_arbitration();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
